// File: rtl/nec_rx_decoder.sv
// NEC IR frame decoder: pin synchronizer, glitch filter, half-unit duration measurement, frame/repeat FSM.
// Optional define NEC_CHECK_INVERSE_EN enables the address/command inverse-byte check.
module nec_rx_decoder #(
    parameter int unsigned HALF_CYC = 14062,
    parameter int unsigned FILT_CYC = 100
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       remote_in,
    output logic       data_valid,
    output logic [7:0] addr,
    output logic [7:0] cmd,
    output logic       rep_valid,
    output logic       err
);

    localparam int unsigned PW = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
    localparam int unsigned FW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE, S_STOP_MARK, S_REP_STOP
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_sync;
    logic [FW-1:0]   r_fcnt;
    logic            r_lvl, r_lvl_q;
    logic [PW-1:0]   r_pre;
    logic [5:0]      r_dur;
    logic [31:0]     r_sr, w_sr_nxt;
    logic [4:0]      r_bcnt, w_bcnt_nxt;
    logic [7:0]      w_addr_nxt, w_cmd_nxt;
    logic            w_dv, w_rv, w_err;
    logic            w_rise, w_fall, w_edge, w_inv_ok;

    function automatic logic in_win(input logic [5:0] d, input logic [5:0] lo, input logic [5:0] hi);
        return (d >= lo) && (d <= hi);
    endfunction

    assign w_rise = r_lvl & ~r_lvl_q;
    assign w_fall = ~r_lvl & r_lvl_q;
    assign w_edge = w_rise | w_fall;

`ifdef NEC_CHECK_INVERSE_EN
    assign w_inv_ok = (r_sr[15:8] == ~r_sr[7:0]) && (r_sr[31:24] == ~r_sr[23:16]);
`else
    assign w_inv_ok = 1'b1;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync  <= 2'b11;
            r_fcnt  <= '0;
            r_lvl   <= 1'b1;
            r_lvl_q <= 1'b1;
        end else begin
            r_sync  <= {r_sync[0], remote_in};
            r_lvl_q <= r_lvl;
            if (r_sync[1] != r_lvl) begin
                if (r_fcnt == FW'(FILT_CYC - 1)) begin
                    r_lvl  <= r_sync[1];
                    r_fcnt <= '0;
                end else begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end else begin
                r_fcnt <= '0;
            end
        end
    end

    // Prescaler restarts at 1 so the edge-detect cycle itself counts; dur = floor(len / half-unit).
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_pre <= '0;
            r_dur <= '0;
        end else if (w_edge) begin
            r_pre <= PW'(1);
            r_dur <= '0;
        end else if (r_pre == PW'(HALF_CYC - 1)) begin
            r_pre <= '0;
            if (r_dur != 6'd63) r_dur <= r_dur + 6'd1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_bcnt_nxt  = r_bcnt;
        w_addr_nxt  = addr;
        w_cmd_nxt   = cmd;
        w_dv        = 1'b0;
        w_rv        = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: if (w_fall) w_state_nxt = S_LEAD_MARK;
            S_LEAD_MARK: if (w_rise) begin
                if (in_win(r_dur, 6'd28, 6'd36)) w_state_nxt = S_LEAD_SPACE;
                else begin w_err = 1'b1; w_state_nxt = S_IDLE; end
            end
            S_LEAD_SPACE: if (w_fall) begin
                if (in_win(r_dur, 6'd14, 6'd18)) begin
                    w_state_nxt = S_BIT_MARK;
                    w_bcnt_nxt  = '0;
                end else if (in_win(r_dur, 6'd6, 6'd10)) begin
                    w_state_nxt = S_REP_STOP;
                end else begin
                    w_err = 1'b1; w_state_nxt = S_LEAD_MARK;
                end
            end
            S_BIT_MARK: if (w_rise) begin
                if (in_win(r_dur, 6'd1, 6'd3)) w_state_nxt = S_BIT_SPACE;
                else begin w_err = 1'b1; w_state_nxt = S_IDLE; end
            end
            S_BIT_SPACE: if (w_fall) begin
                if (in_win(r_dur, 6'd1, 6'd3) || in_win(r_dur, 6'd5, 6'd7)) begin
                    w_sr_nxt   = {in_win(r_dur, 6'd5, 6'd7), r_sr[31:1]};
                    w_bcnt_nxt = r_bcnt + 5'd1;
                    w_state_nxt = (r_bcnt == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
                end else begin
                    w_err = 1'b1; w_state_nxt = S_LEAD_MARK;
                end
            end
            S_STOP_MARK: if (w_rise) begin
                w_state_nxt = S_IDLE;
                if (in_win(r_dur, 6'd1, 6'd3) && w_inv_ok) begin
                    w_dv       = 1'b1;
                    w_addr_nxt = r_sr[7:0];
                    w_cmd_nxt  = r_sr[23:16];
                end else begin
                    w_err = 1'b1;
                end
            end
            S_REP_STOP: if (w_rise) begin
                w_state_nxt = S_IDLE;
                if (in_win(r_dur, 6'd1, 6'd3)) w_rv = 1'b1;
                else w_err = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (r_state != S_IDLE && !w_edge && r_dur >= 6'd40) begin
            w_err       = 1'b1;
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= S_IDLE;
            r_sr       <= '0;
            r_bcnt     <= '0;
            addr       <= '0;
            cmd        <= '0;
            data_valid <= 1'b0;
            rep_valid  <= 1'b0;
            err        <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sr       <= w_sr_nxt;
            r_bcnt     <= w_bcnt_nxt;
            addr       <= w_addr_nxt;
            cmd        <= w_cmd_nxt;
            data_valid <= w_dv;
            rep_valid  <= w_rv;
            err        <= w_err;
        end
    end

endmodule

// File: tb/tb_nec_rx_decoder.sv
// Directed bench for nec_rx_decoder with HALF_CYC=10, FILT_CYC=4; strobes are counted by a negedge monitor.
module tb_nec_rx_decoder;

    localparam int unsigned HC = 10;
    localparam int unsigned FC = 4;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       remote_in = 1'b1;
    logic       data_valid, rep_valid, err;
    logic [7:0] addr, cmd;

    nec_rx_decoder #(.HALF_CYC(HC), .FILT_CYC(FC)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .remote_in (remote_in),
        .data_valid(data_valid),
        .addr      (addr),
        .cmd       (cmd),
        .rep_valid (rep_valid),
        .err       (err)
    );

    always #5 sys_clk = ~sys_clk;

    int unsigned cyc = 0;
    int unsigned n_dv = 0, n_rv = 0, n_err = 0, n_overlap = 0, last_err_cyc = 0;
    int unsigned s_dv, s_rv, s_err;
    int unsigned n_checks = 0, n_pass = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (data_valid) n_dv <= n_dv + 1;
        if (rep_valid)  n_rv <= n_rv + 1;
        if (err) begin
            n_err        <= n_err + 1;
            last_err_cyc <= cyc;
        end
        if ((int'(data_valid) + int'(rep_valid) + int'(err)) > 1) n_overlap <= n_overlap + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic snap();
        s_dv  = n_dv;
        s_rv  = n_rv;
        s_err = n_err;
    endtask

    task automatic level(input logic v, input int unsigned units);
        remote_in = v;
        repeat (units * HC) @(negedge sys_clk);
    endtask

    // Space with a 3-cycle low glitch near its start, shorter than the filter window.
    task automatic space_glitch(input int unsigned units);
        remote_in = 1'b1;
        repeat (8) @(negedge sys_clk);
        remote_in = 1'b0;
        repeat (3) @(negedge sys_clk);
        remote_in = 1'b1;
        repeat (units * HC - 11) @(negedge sys_clk);
    endtask

    task automatic send_bits(input logic [31:0] w, input int unsigned nbits, input bit glitch);
        for (int i = 0; i < int'(nbits); i++) begin
            level(1'b0, 2);
            if (glitch) space_glitch(w[i] ? 6 : 2);
            else        level(1'b1, w[i] ? 6 : 2);
        end
    endtask

    task automatic send_frame(input logic [31:0] w, input bit glitch);
        level(1'b0, 32);
        level(1'b1, 16);
        send_bits(w, 32, glitch);
        level(1'b0, 2);
        level(1'b1, 10);
    endtask

    int unsigned t0, d;

    initial begin
        @(negedge sys_clk);
        repeat (4) @(negedge sys_clk);
        check("rst_dv", data_valid, 0);
        check("rst_rv", rep_valid, 0);
        check("rst_err", err, 0);
        check("rst_addr", addr, 8'h00);
        check("rst_cmd", cmd, 8'h00);
        sys_rst_n = 1'b1;
        level(1'b1, 5);

        snap();
        send_frame(32'hBA45FF00, 1'b0);
        check("f1_dv", n_dv - s_dv, 1);
        check("f1_err", n_err - s_err, 0);
        check("f1_addr", addr, 8'h00);
        check("f1_cmd", cmd, 8'h45);

        snap();
        level(1'b0, 32);
        level(1'b1, 8);
        level(1'b0, 2);
        level(1'b1, 10);
        check("rep_rv", n_rv - s_rv, 1);
        check("rep_dv", n_dv - s_dv, 0);
        check("rep_addr", addr, 8'h00);
        check("rep_cmd", cmd, 8'h45);

        snap();
        send_frame(32'hBB45FF00, 1'b0);
`ifdef NEC_CHECK_INVERSE_EN
        check("inv_err", n_err - s_err, 1);
        check("inv_dv", n_dv - s_dv, 0);
`else
        check("inv_err", n_err - s_err, 0);
        check("inv_dv", n_dv - s_dv, 1);
`endif
        check("inv_addr", addr, 8'h00);
        check("inv_cmd", cmd, 8'h45);

        snap();
        send_frame(32'hCB34ED12, 1'b1);
        check("gl_dv", n_dv - s_dv, 1);
        check("gl_err", n_err - s_err, 0);
        check("gl_addr", addr, 8'h12);
        check("gl_cmd", cmd, 8'h34);

        snap();
        level(1'b0, 32);
        level(1'b1, 16);
        send_bits(32'hC33C5AA5, 10, 1'b0);
        level(1'b0, 2);
        t0 = cyc;
        level(1'b1, 45);
        d = last_err_cyc - t0;
        check("to_err", n_err - s_err, 1);
        check("to_dv", n_dv - s_dv, 0);
        check("to_latency", (d >= 400 && d <= 415) ? 1 : 0, 1);
        snap();
        send_frame(32'hC33C5AA5, 1'b0);
        check("to_next_dv", n_dv - s_dv, 1);
        check("to_next_err", n_err - s_err, 0);
        check("to_next_addr", addr, 8'hA5);
        check("to_next_cmd", cmd, 8'h3C);

        snap();
        level(1'b0, 32);
        level(1'b1, 16);
        level(1'b0, 2);
        level(1'b1, 4);
        send_frame(32'h7F80FE01, 1'b0);
        check("sp4_err", n_err - s_err, 1);
        check("sp4_dv", n_dv - s_dv, 1);
        check("sp4_addr", addr, 8'h01);
        check("sp4_cmd", cmd, 8'h80);

        snap();
        level(1'b0, 32);
        level(1'b1, 16);
        send_bits(32'h9966AA55, 20, 1'b0);
        level(1'b0, 1);
        sys_rst_n = 1'b0;
        remote_in = 1'b1;
        @(negedge sys_clk);
        check("mr_addr", addr, 8'h00);
        check("mr_cmd", cmd, 8'h00);
        check("mr_dv", data_valid, 0);
        repeat (5) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        level(1'b1, 60);
        check("mr_no_dv", n_dv - s_dv, 0);
        check("mr_no_err", n_err - s_err, 0);
        snap();
        send_frame(32'h9966AA55, 1'b0);
        check("mr_next_dv", n_dv - s_dv, 1);
        check("mr_next_addr", addr, 8'h55);
        check("mr_next_cmd", cmd, 8'h66);

        check("onehot", n_overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nec_rx_decoder.md
# nec_rx_decoder

NEC infrared frame decoder that sits directly upstream of the UART transmit stage in the NEC-to-UART bridge. It synchronizes and de-glitches the raw IR receiver pin, then measures mark/space durations against the NEC timing grid. It decodes 32-bit frames and repeat codes. It presents the address/command bytes with a one-cycle valid strobe for the UART stage to serialize.

## Interface
- `HALF_CYC`, default 14062: `sys_clk` cycles per NEC half-unit (281.25 µs at 50 MHz); benches override it small.
- `FILT_CYC`, default 100: consecutive stable cycles required before the filtered level changes (2 µs at 50 MHz).
- `sys_clk`  in  1  system clock, single clock domain.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `remote_in`  in  1  raw IR receiver output, asynchronous; idle high, low = carrier (mark).
- `data_valid`  out  1  one-cycle strobe: a complete frame was accepted.
- `addr`  out  8  address byte of the last accepted frame.
- `cmd`  out  8  command byte of the last accepted frame.
- `rep_valid`  out  1  one-cycle strobe: a valid repeat code was received.
- `err`  out  1  one-cycle strobe: a frame was aborted (bad timing, timeout, inverse mismatch).

## Operation
- Input path: 2-flop synchronizer, then glitch filter; the filtered level `lvl` (reset 1) flips only after `FILT_CYC` consecutive samples of the opposite value.
- Duration: prescaler 0..`HALF_CYC`-1 drives `dur`, a 6-bit counter of half-units saturating at 63; both clear on every `lvl` edge. At an edge, `dur` = floor(length / half-unit).
- Windows, in half-units inclusive:
  - lead mark 28..36
  - lead space 14..18
  - repeat space 6..10
  - bit/stop mark 1..3
  - space '0' 1..3
  - space '1' 5..7
- States and transitions:
  - IDLE: falling edge → LEAD_MARK.
  - LEAD_MARK: on rise, in window → LEAD_SPACE.
  - LEAD_SPACE: on fall, lead space → BIT_MARK with bit count 0; repeat space → REP_STOP.
  - BIT_MARK: on rise, in window → BIT_SPACE.
  - BIT_SPACE: on fall, '0'/'1' shifts the bit into a 32-bit register, LSB first (`sr <= {b, sr[31:1]}`). Bit count 31 → STOP_MARK, else → BIT_MARK.
  - STOP_MARK: on rise, in window → frame check → IDLE.
  - REP_STOP: on rise, in window → `rep_valid` → IDLE.
- Byte map: `sr[7:0]` address, `sr[15:8]` inverted address, `sr[23:16]` command, `sr[31:24]` inverted command.
- Errors: an edge whose duration falls outside its state's window, or `dur` reaching 40 in any non-IDLE state, pulses `err`.
  - Error on a rising edge or timeout → IDLE.
  - Error on a falling edge → LEAD_MARK (resync on that mark).
- `addr`/`cmd` update only in the cycle `data_valid` is high; otherwise they hold. `rep_valid` never alters them.

## Timing
- Reset values: `data_valid`, `rep_valid`, `err` = 0; `addr`, `cmd` = 0x00; state IDLE; filter level 1.
- Pin-to-`lvl` latency: 2 + `FILT_CYC` cycles.
- All outputs are registered and assert in the cycle after the terminating `lvl` rising edge is seen. Each strobe lasts exactly 1 cycle.
- At most one of `data_valid`/`rep_valid`/`err` is high in any cycle.
- No handshake: the downstream stage must capture on the strobe. Frames are ≥ 108 ms apart at default timing.
- Reset mid-frame: immediate return to reset values; the partial frame is discarded with no `err`.
- Saturation: `dur` holds at 63; `lvl` held low in IDLE causes no output.

## Configuration
- `NEC_CHECK_INVERSE_EN` defined: at STOP_MARK completion, `sr[15:8]` must equal `~sr[7:0]` and `sr[31:24]` must equal `~sr[23:16]`. On mismatch, pulse `err` instead of `data_valid`; `addr`/`cmd` are unchanged.
- Undefined: no check is performed (extended-NEC addresses pass). `data_valid` is always pulsed, with `addr = sr[7:0]` and `cmd = sr[23:16]`.

## Test plan
Benches use `HALF_CYC`=10 and `FILT_CYC`=4.
- Standard frame, addr 0x00 / cmd 0x45 (bytes 00 FF 45 BA) → one `data_valid`; `addr`=0x00, `cmd`=0x45; `err`=0.
- Repeat code after that frame (32 half-unit mark, 8 space, 2 mark) → one `rep_valid`; `addr`/`cmd` still 0x00/0x45.
- Frame 00 FF 45 BB:
  - with `NEC_CHECK_INVERSE_EN` → `err` pulse, no `data_valid`, outputs hold.
  - without it → `data_valid`, `cmd`=0x45.
- 3-cycle low glitches injected inside spaces of a 0x12/0x34 frame → decoded `addr`=0x12, `cmd`=0x34 with no `err`.
- Timing faults:
  - Pin held high 45 half-units after bit 10 → single `err` 40 half-units into the space, state IDLE; a following good frame decodes.
  - A space of 4 half-units → `err`.
- `sys_rst_n` pulsed low during bit 20 → all outputs 0 immediately; no strobe for that frame; the next full frame decodes.
